fpnew_noncomp_wb: RTL and testbench

- Result-side consumer for a non-computational FP lane (sign-injection, min/max, compare, classify). It sits downstream of the lane's output valid/ready handshake.
- Accepts lane responses into a small FIFO and formats each to XLEN: class masks are zero-extended, other results are padded with the extension bit.
- Presents formatted results to integer/FP regfile writeback and keeps the sticky accrued exception flags (fflags).

---
 rtl/fpnew_noncomp_wb.sv | 149 ++++++++++++++
 tb/tb_fpnew_noncomp_wb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_noncomp_wb.sv
// Writeback stage for the non-computational FP lane: buffers lane responses,
// widens them to XLEN, and accrues the sticky exception flags on retirement.
module fpnew_noncomp_wb #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned XLEN     = 64,
  parameter int unsigned TagWidth = 4,
  parameter int unsigned Depth    = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WIDTH-1:0]    result_i,
  input  logic [4:0]          status_i,
  input  logic                extension_bit_i,
  input  logic [9:0]          class_mask_i,
  input  logic                is_class_i,
  input  logic [TagWidth-1:0] tag_i,
  input  logic                flush_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [XLEN-1:0]     wb_data_o,
  output logic [TagWidth-1:0] wb_tag_o,
  output logic [4:0]          wb_status_o,
  output logic [4:0]          fflags_o,
  input  logic                fflags_clr_i,
  output logic                busy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [XLEN-1:0]     data_mem_r   [Depth];
  logic [TagWidth-1:0] tag_mem_r    [Depth];
  logic [4:0]          status_mem_r [Depth];
  logic [PtrW-1:0]     wr_ptr_r;
  logic [PtrW-1:0]     rd_ptr_r;
  logic [CntW-1:0]     count_r;
  logic [4:0]          fflags_r;

  logic                push_s;
  logic                pop_s;
  logic                full_s;
  logic                empty_s;
  logic [XLEN-1:0]     fmt_data_s;

  // Class masks are zero-extended; everything else is filled with the extension bit
  // (sign extension for integer results, NaN-boxing for narrow FP results).
  function automatic logic [XLEN-1:0] format_result(
    input logic [WIDTH-1:0] res,
    input logic             ext,
    input logic [9:0]       mask,
    input logic             is_cls
  );
    logic [XLEN-1:0] word;
    if (is_cls) begin
      word       = {XLEN{1'b0}};
      word[9:0]  = mask;
    end else begin
      word              = {XLEN{ext}};
      word[WIDTH-1:0]   = res;
    end
    return word;
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    logic [PtrW-1:0] nxt;
    if (ptr == LastPtr) begin
      nxt = {PtrW{1'b0}};
    end else begin
      nxt = ptr + PtrW'(1);
    end
    return nxt;
  endfunction

  // Handshake qualification and push-time formatting.
  always_comb begin
    full_s     = (count_r == FullCnt);
    empty_s    = (count_r == {CntW{1'b0}});
    push_s     = in_valid_i & ~full_s & ~flush_i;
    pop_s      = ~empty_s & wb_ready_i & ~flush_i;
    fmt_data_s = format_result(result_i, extension_bit_i, class_mask_i, is_class_i);
  end

  // Pointer and occupancy bookkeeping; flush drops everything buffered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      count_r  <= {CntW{1'b0}};
    end else if (flush_i) begin
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      count_r  <= {CntW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, cleared on reset so an empty FIFO reads back zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        data_mem_r[i]   <= {XLEN{1'b0}};
        tag_mem_r[i]    <= {TagWidth{1'b0}};
        status_mem_r[i] <= 5'b00000;
      end
    end else if (push_s) begin
      data_mem_r[wr_ptr_r]   <= fmt_data_s;
      tag_mem_r[wr_ptr_r]    <= tag_i;
      status_mem_r[wr_ptr_r] <= status_i;
    end
  end

  // Sticky flags: a clear coinciding with a retirement keeps only the new status.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fflags_r <= 5'b00000;
    end else begin
      case ({fflags_clr_i, pop_s})
        2'b11:   fflags_r <= status_mem_r[rd_ptr_r];
        2'b01:   fflags_r <= fflags_r | status_mem_r[rd_ptr_r];
        2'b10:   fflags_r <= 5'b00000;
        default: fflags_r <= fflags_r;
      endcase
    end
  end

  assign in_ready_o  = ~full_s;
  assign wb_valid_o  = ~empty_s;
  assign busy_o      = ~empty_s;
  assign wb_data_o   = data_mem_r[rd_ptr_r];
  assign wb_tag_o    = tag_mem_r[rd_ptr_r];
  assign wb_status_o = status_mem_r[rd_ptr_r];
  assign fflags_o    = fflags_r;

endmodule

// File: tb/tb_fpnew_noncomp_wb.sv
// Scoreboard bench for fpnew_noncomp_wb: the driver queues expected writebacks,
// a negedge monitor compares every presented head entry against the queue.
module tb_fpnew_noncomp_wb;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] result_i = 32'h0;
  logic [4:0]  status_i = 5'h0;
  logic        extension_bit_i = 1'b0;
  logic [9:0]  class_mask_i = 10'h0;
  logic        is_class_i = 1'b0;
  logic [3:0]  tag_i = 4'h0;
  logic        flush_i = 1'b0;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b0;
  logic [63:0] wb_data_o;
  logic [3:0]  wb_tag_o;
  logic [4:0]  wb_status_o;
  logic [4:0]  fflags_o;
  logic        fflags_clr_i = 1'b0;
  logic        busy_o;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    logic [4:0]  st;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  fpnew_noncomp_wb #(.WIDTH(32), .XLEN(64), .TagWidth(4), .Depth(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .result_i(result_i), .status_i(status_i), .extension_bit_i(extension_bit_i),
    .class_mask_i(class_mask_i), .is_class_i(is_class_i), .tag_i(tag_i),
    .flush_i(flush_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
    .wb_tag_o(wb_tag_o), .wb_status_o(wb_status_o),
    .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: head must match the oldest expected entry; retire it on a pop.
  always @(negedge clk) begin
    if (rst_ni && wb_valid_o) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got tag=%0d data=%h, none expected", wb_tag_o, wb_data_o);
      end else begin
        if (wb_data_o !== sb_q[0].data || wb_tag_o !== sb_q[0].tag || wb_status_o !== sb_q[0].st) begin
          errors++;
          $display("FAIL wb_entry: got tag=%0d data=%h st=%b expected tag=%0d data=%h st=%b",
                   wb_tag_o, wb_data_o, wb_status_o, sb_q[0].tag, sb_q[0].data, sb_q[0].st);
        end
        if (wb_ready_i && !flush_i) void'(sb_q.pop_front());
      end
    end
  end

  // Drive one response and hold it until accepted; called and returning at posedge+1.
  task automatic send(input logic [31:0] res, input logic ext, input logic [9:0] mask,
                      input logic cls, input logic [3:0] tag, input logic [4:0] st,
                      input logic [63:0] exp_data);
    bit done;
    done = 1'b0;
    result_i = res; extension_bit_i = ext; class_mask_i = mask;
    is_class_i = cls; tag_i = tag; status_i = st; in_valid_i = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready_o && !flush_i) begin
        sb_q.push_back('{exp_data, tag, st});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tag %0d not accepted within 20 cycles", tag);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    check("rst_wb_valid", 64'(wb_valid_o), 64'h0);
    check("rst_in_ready", 64'(in_ready_o), 64'h1);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_fflags", 64'(fflags_o), 64'h0);
    check("rst_wb_data", wb_data_o, 64'h0);
    check("rst_wb_tag_status", {55'h0, wb_tag_o, wb_status_o}, 64'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    idle(1);

    // Classify formatting, first-cycle visibility
    wb_ready_i = 1'b1;
    send(32'hFFFF_FFFF, 1'b1, 10'h040, 1'b1, 4'd1, 5'b00000, 64'h0000_0000_0000_0040);
    check("class_latency_valid", 64'(wb_valid_o), 64'h1);
    check("class_data", wb_data_o, 64'h0000_0000_0000_0040);
    idle(2);

    // NaN-box vs zero fill
    send(32'h8000_0001, 1'b1, 10'h000, 1'b0, 4'd2, 5'b00000, 64'hFFFF_FFFF_8000_0001);
    send(32'h8000_0001, 1'b0, 10'h000, 1'b0, 4'd3, 5'b00000, 64'h0000_0000_8000_0001);
    idle(3);

    // Backpressure and full refusal with simultaneous pop
    wb_ready_i = 1'b0;
    send(32'h0000_0011, 1'b0, 10'h000, 1'b0, 4'd1, 5'b00000, 64'h0000_0000_0000_0011);
    send(32'h0000_0022, 1'b0, 10'h000, 1'b0, 4'd2, 5'b00000, 64'h0000_0000_0000_0022);
    check("full_in_ready", 64'(in_ready_o), 64'h0);
    result_i = 32'h0000_0033; extension_bit_i = 1'b0; is_class_i = 1'b0;
    tag_i = 4'd3; status_i = 5'b00000; in_valid_i = 1'b1; wb_ready_i = 1'b1;
    @(negedge clk);
    check("full_refuse_with_pop", 64'(in_ready_o), 64'h0);
    @(posedge clk); #1;
    wb_ready_i = 1'b0;
    check("after_pop_in_ready", 64'(in_ready_o), 64'h1);
    send(32'h0000_0033, 1'b0, 10'h000, 1'b0, 4'd3, 5'b00000, 64'h0000_0000_0000_0033);
    check("refull_in_ready", 64'(in_ready_o), 64'h0);
    wb_ready_i = 1'b1;
    idle(4);
    check("order_drained", 64'(sb_q.size()), 64'h0);

    // Sticky flags, then clear together with a pop
    send(32'h0000_0044, 1'b0, 10'h000, 1'b0, 4'd4, 5'b10000, 64'h0000_0000_0000_0044);
    send(32'h0000_0055, 1'b0, 10'h000, 1'b0, 4'd5, 5'b00001, 64'h0000_0000_0000_0055);
    idle(2);
    check("fflags_accrue", 64'(fflags_o), 64'h11);
    wb_ready_i = 1'b0;
    send(32'h0000_0066, 1'b0, 10'h000, 1'b0, 4'd6, 5'b00100, 64'h0000_0000_0000_0066);
    fflags_clr_i = 1'b1; wb_ready_i = 1'b1;
    @(posedge clk); #1;
    fflags_clr_i = 1'b0; wb_ready_i = 1'b0;
    check("fflags_clr_and_pop", 64'(fflags_o), 64'h04);
    fflags_clr_i = 1'b1;
    @(posedge clk); #1;
    fflags_clr_i = 1'b0;
    check("fflags_clr_only", 64'(fflags_o), 64'h00);
    wb_ready_i = 1'b1;
    send(32'h0000_0077, 1'b0, 10'h000, 1'b0, 4'd7, 5'b00001, 64'h0000_0000_0000_0077);
    idle(2);
    check("fflags_setup", 64'(fflags_o), 64'h01);

    // Flush with two entries buffered
    wb_ready_i = 1'b0;
    send(32'h0000_0088, 1'b0, 10'h000, 1'b0, 4'd8, 5'b00010, 64'h0000_0000_0000_0088);
    send(32'h0000_0099, 1'b0, 10'h000, 1'b0, 4'd9, 5'b01000, 64'h0000_0000_0000_0099);
    result_i = 32'h0000_00AA; tag_i = 4'd10; status_i = 5'b10000;
    in_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    sb_q.delete();
    check("flush_wb_valid", 64'(wb_valid_o), 64'h0);
    check("flush_busy", 64'(busy_o), 64'h0);
    check("flush_in_ready", 64'(in_ready_o), 64'h1);
    check("flush_fflags", 64'(fflags_o), 64'h01);
    wb_ready_i = 1'b1;
    idle(3);

    // Flush with room available: the same-cycle response must be discarded
    wb_ready_i = 1'b0;
    send(32'h0000_00BB, 1'b0, 10'h000, 1'b0, 4'd13, 5'b00000, 64'h0000_0000_0000_00BB);
    result_i = 32'h0000_00CC; tag_i = 4'd14; in_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    sb_q.delete();
    check("flush_discard_valid", 64'(wb_valid_o), 64'h0);
    wb_ready_i = 1'b1;
    idle(3);
    check("flush_discard_busy", 64'(busy_o), 64'h0);

    // Post-flush traffic across the pointer wrap
    send(32'h7FFF_0000, 1'b1, 10'h000, 1'b0, 4'd11, 5'b00000, 64'hFFFF_FFFF_7FFF_0000);
    send(32'h0000_0000, 1'b0, 10'h200, 1'b1, 4'd12, 5'b00000, 64'h0000_0000_0000_0200);
    send(32'h1357_9BDF, 1'b0, 10'h000, 1'b0, 4'd15, 5'b00000, 64'h0000_0000_1357_9BDF);
    idle(3);
    check("wrap_drained", 64'(sb_q.size()), 64'h0);

    // Asynchronous reset between edges
    wb_ready_i = 1'b0;
    send(32'h0000_1234, 1'b0, 10'h000, 1'b0, 4'd6, 5'b00010, 64'h0000_0000_0000_1234);
    #2;
    rst_ni = 1'b0;
    sb_q.delete();
    #1;
    check("async_rst_wb_valid", 64'(wb_valid_o), 64'h0);
    check("async_rst_fflags", 64'(fflags_o), 64'h0);
    check("async_rst_busy", 64'(busy_o), 64'h0);
    check("async_rst_data", wb_data_o, 64'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    idle(2);
    check("final_queue_empty", 64'(sb_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
